fetch_request_unit: RTL and testbench

- Multi-cycle front end for the single-cycle MIPS core. Holds the PC, fetches instructions, and sequences the instruction-memory and data-memory requests.
- Feeds the latched instruction to the control unit, and consumes its PCSrc/dREN/dWEN/halt outputs.
- Commits the next PC (sequential, branch, jump, jr) once each instruction's memory traffic completes.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/fetch_request_unit_if.sv | 45 ++++
 rtl/next_pc_calc.sv | 39 +++
 rtl/fetch_request_unit.sv | 127 ++++++++++++
 tb/tb_fetch_request_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the single-cycle MIPS core front end.
// Holds the datapath word type, the PC-source select encoding and the
// fetch/request sequencer states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Matches the control unit's PCSrc encoding.
    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        DATA   = 2'd2,
        HALTED = 2'd3
    } fru_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_request_unit_if.sv
// Bundle between the fetch/request unit and its memory + control-unit peers.
// master: the fetch_request_unit side (drives requests, pc, instr, commit).
// slave : memory / control unit / datapath side (drives hits, loads, decode).
interface fetch_request_unit_if;
    import cpu_types_pkg::*;

    // memory side
    logic   ihit;
    logic   dhit;
    word_t  imemload;
    word_t  dmemload;
    logic   imemREN;
    word_t  imemaddr;
    logic   dmemREN;
    logic   dmemWEN;

    // control unit / datapath side
    pcsrc_t pcsrc;
    logic   cu_dren;
    logic   cu_dwen;
    logic   cu_halt;
    logic   branch_taken;
    word_t  rs_data;
    word_t  pc;
    word_t  npc;
    word_t  instr;
    word_t  load_data;
    logic   commit;
    logic   halt;

    modport master (
        input  ihit, dhit, imemload, dmemload,
        input  pcsrc, cu_dren, cu_dwen, cu_halt, branch_taken, rs_data,
        output imemREN, imemaddr, dmemREN, dmemWEN,
        output pc, npc, instr, load_data, commit, halt
    );

    modport slave (
        output ihit, dhit, imemload, dmemload,
        output pcsrc, cu_dren, cu_dwen, cu_halt, branch_taken, rs_data,
        input  imemREN, imemaddr, dmemREN, dmemWEN,
        input  pc, npc, instr, load_data, commit, halt
    );

endinterface

// File: rtl/next_pc_calc.sv
// Next-PC selection: sequential, branch, jump or jump-register target.
// Latency: purely combinational.
// Backpressure: none; the caller decides when next_pc is committed.
// Ports: pc, instr, pcsrc, branch_taken, rs_data in; next_pc out.
module next_pc_calc
    import cpu_types_pkg::*;
(
    input  word_t  pc,
    input  word_t  instr,
    input  pcsrc_t pcsrc,
    input  logic   branch_taken,
    input  word_t  rs_data,
    output word_t  next_pc
);

    word_t seq_pc;
    word_t br_off;

    assign seq_pc = pc + PC_STEP;
    // Sign-extended word offset converted to a byte offset.
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = seq_pc;
        case (pcsrc)
            PC_SEQ:  next_pc = seq_pc;
            PC_BR:   next_pc = branch_taken ? (seq_pc + br_off) : seq_pc;
            // Jump region comes from pc+4, not pc.
            PC_J:    next_pc = {seq_pc[31:28], instr[25:0], 2'b00};
            PC_JR:   next_pc = {rs_data[31:2], 2'b00};
            default: next_pc = seq_pc;
        endcase
    end

    // Opcode field and the low jr bits are intentionally not used here.
    logic unused_bits;
    assign unused_bits = ^{instr[31:26], rs_data[1:0]};

endmodule

// File: rtl/fetch_request_unit.sv
// Multi-cycle front end: holds PC, fetches, sequences imem/dmem requests, commits next PC.
// Latency: 1 cycle past ihit for ALU/branch/jump; 1 cycle plus dhit wait for loads/stores.
// Backpressure: waits indefinitely on ihit (FETCH) and dhit (DATA); requests never overlap.
// Ports: CLK, nRST (async active-low), bus (fetch_request_unit_if.master).
// Optional FRU_PERF_CNT_EN adds cycle_cnt (non-halted cycles) and retire_cnt (commits).
module fetch_request_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter int    WORD_W  = 32
) (
    input  logic CLK,
    input  logic nRST,
    fetch_request_unit_if.master bus
`ifdef FRU_PERF_CNT_EN
    ,
    output word_t cycle_cnt,
    output word_t retire_cnt
`endif
);

    fru_state_t       state, state_nxt;
    logic [WORD_W-1:0] pc_q;
    word_t            instr_q;
    word_t            load_q;
    logic             halt_q;
    word_t            next_pc;

    logic imem_ren, dmem_ren, dmem_wen, commit_c;
    logic pc_ld, instr_ld, load_ld, halt_set;

    next_pc_calc u_next_pc (
        .pc           (pc_q),
        .instr        (instr_q),
        .pcsrc        (bus.pcsrc),
        .branch_taken (bus.branch_taken),
        .rs_data      (bus.rs_data),
        .next_pc      (next_pc)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= FETCH;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            load_q  <= '0;
            halt_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pc_ld)    pc_q    <= next_pc;
            if (instr_ld) instr_q <= bus.imemload;
            if (load_ld)  load_q  <= bus.dmemload;
            if (halt_set) halt_q  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_ren  = 1'b0;
        dmem_ren  = 1'b0;
        dmem_wen  = 1'b0;
        commit_c  = 1'b0;
        pc_ld     = 1'b0;
        instr_ld  = 1'b0;
        load_ld   = 1'b0;
        halt_set  = 1'b0;
        case (state)
            FETCH: begin
                imem_ren = 1'b1;
                if (bus.ihit) begin
                    instr_ld  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            // Decode cycle: no requests so the control unit sees a stable instr.
            EXEC: begin
                if (bus.cu_halt) begin
                    halt_set  = 1'b1;
                    state_nxt = HALTED;
                end else if (bus.cu_dren || bus.cu_dwen) begin
                    state_nxt = DATA;
                end else begin
                    commit_c  = 1'b1;
                    pc_ld     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DATA: begin
                // A write takes priority over a read if decode asserts both.
                dmem_wen = bus.cu_dwen;
                dmem_ren = bus.cu_dren && !bus.cu_dwen;
                if (bus.dhit) begin
                    load_ld   = 1'b1;
                    commit_c  = 1'b1;
                    pc_ld     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = FETCH;
        endcase
    end

    assign bus.imemREN   = imem_ren;
    assign bus.imemaddr  = pc_q;
    assign bus.dmemREN   = dmem_ren;
    assign bus.dmemWEN   = dmem_wen;
    assign bus.pc        = pc_q;
    assign bus.npc       = pc_q + PC_STEP;
    assign bus.instr     = instr_q;
    assign bus.load_data = load_q;
    assign bus.commit    = commit_c;
    assign bus.halt      = halt_q;

`ifdef FRU_PERF_CNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state != HALTED) cycle_cnt  <= cycle_cnt + 32'd1;
            if (commit_c)        retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_request_unit.sv
// Randomized self-checking bench for fetch_request_unit against a
// transaction-level model of PC sequencing and request timing.
module tb_fetch_request_unit;
    import cpu_types_pkg::*;

    localparam word_t PC_INIT = 32'h0000_0000;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    fetch_request_unit_if bus ();

`ifdef FRU_PERF_CNT_EN
    word_t cycle_cnt, retire_cnt;
`endif

    fetch_request_unit #(.PC_INIT(PC_INIT), .WORD_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.master)
`ifdef FRU_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    word_t       m_pc;
    bit          m_halted;
    int unsigned m_cycles;
    int unsigned m_retired;

    task automatic check_eq(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_perf();
`ifdef FRU_PERF_CNT_EN
        check_eq("cycle_cnt", cycle_cnt, word_t'(m_cycles));
        check_eq("retire_cnt", retire_cnt, word_t'(m_retired));
`endif
    endtask

    // Advance one clock; model counts cycles the unit spent outside HALTED.
    task automatic end_cycle();
        @(posedge CLK);
        if (nRST && !m_halted) m_cycles++;
        #1;
    endtask

    function automatic word_t model_next(input word_t pc, input word_t iw,
                                         input logic [1:0] ps, input bit bt,
                                         input word_t rs);
        word_t seq;
        int    off;
        seq = pc + 32'd4;
        off = int'($signed(iw[15:0]));
        case (ps)
            2'd0:    return seq;
            2'd1:    return bt ? seq + word_t'(off * 4) : seq;
            2'd2:    return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 32'd4);
            default: return rs & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic do_instr(input word_t iw, input logic [1:0] ps, input bit bt,
                            input word_t rs, input bit dr, input bit dw, input bit hl,
                            input int iwait, input int dwait, input word_t dload);
        word_t exp_pc;
        bit    mem;
        exp_pc = model_next(m_pc, iw, ps, bt, rs);
        mem    = dr | dw;
        bus.pcsrc        = pcsrc_t'(ps);
        bus.branch_taken = bt;
        bus.rs_data      = rs;
        bus.cu_dren      = dr;
        bus.cu_dwen      = dw;
        bus.cu_halt      = hl;
        for (int k = 0; k <= iwait; k++) begin
            bus.ihit     = (k == iwait);
            bus.imemload = (k == iwait) ? iw : word_t'($urandom);
            bus.dhit     = 1'($urandom_range(0, 1));
            bus.dmemload = $urandom;
            @(negedge CLK);
            check_eq("fetch_imemREN", bus.imemREN, 1);
            check_eq("fetch_imemaddr", bus.imemaddr, m_pc);
            check_eq("fetch_dmemREN", bus.dmemREN, 0);
            check_eq("fetch_dmemWEN", bus.dmemWEN, 0);
            check_eq("fetch_commit", bus.commit, 0);
            check_eq("npc", bus.npc, m_pc + 32'd4);
            end_cycle();
        end
        bus.ihit     = 1'($urandom_range(0, 1));
        bus.dhit     = 1'($urandom_range(0, 1));
        bus.imemload = $urandom;
        @(negedge CLK);
        check_eq("exec_instr", bus.instr, iw);
        check_eq("exec_imemREN", bus.imemREN, 0);
        check_eq("exec_dmemREN", bus.dmemREN, 0);
        check_eq("exec_dmemWEN", bus.dmemWEN, 0);
        check_eq("exec_commit", bus.commit, word_t'(!hl && !mem));
        check_eq("exec_pc", bus.pc, m_pc);
        end_cycle();
        if (hl) begin
            m_halted = 1'b1;
        end else if (mem) begin
            for (int k = 0; k <= dwait; k++) begin
                bus.dhit     = (k == dwait);
                bus.dmemload = (k == dwait) ? dload : word_t'($urandom);
                bus.ihit     = 1'($urandom_range(0, 1));
                @(negedge CLK);
                check_eq("data_dmemWEN", bus.dmemWEN, word_t'(dw));
                check_eq("data_dmemREN", bus.dmemREN, word_t'(dr && !dw));
                check_eq("data_imemREN", bus.imemREN, 0);
                check_eq("data_commit", bus.commit, word_t'(k == dwait));
                check_eq("data_pc", bus.pc, m_pc);
                end_cycle();
            end
            check_eq("load_data", bus.load_data, dload);
        end
        if (!hl) begin
            m_retired++;
            m_pc = exp_pc;
        end
        check_eq("pc_after", bus.pc, m_pc);
        check_eq("halt_after", bus.halt, word_t'(hl));
        check_perf();
        bus.ihit = 1'b0;
        bus.dhit = 1'b0;
    endtask

    task automatic check_reset_values(input string where);
        check_eq({where, "_pc"}, bus.pc, PC_INIT);
        check_eq({where, "_instr"}, bus.instr, 0);
        check_eq({where, "_load_data"}, bus.load_data, 0);
        check_eq({where, "_commit"}, bus.commit, 0);
        check_eq({where, "_halt"}, bus.halt, 0);
        check_eq({where, "_dmemREN"}, bus.dmemREN, 0);
        check_eq({where, "_dmemWEN"}, bus.dmemWEN, 0);
        m_pc = PC_INIT; m_halted = 1'b0; m_cycles = 0; m_retired = 0;
        check_perf();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0;
        bus.ihit = 0; bus.dhit = 0; bus.imemload = 0; bus.dmemload = 0;
        bus.pcsrc = PC_SEQ; bus.cu_dren = 0; bus.cu_dwen = 0; bus.cu_halt = 0;
        bus.branch_taken = 0; bus.rs_data = 0;
        #2;
        check_reset_values("reset");
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // addiu, two wait cycles before ihit
        do_instr(32'h2401_0005, 2'd0, 0, 0, 0, 0, 0, 2, 0, 0);
        // beq back to itself taken / not taken at pc=0x10
        do_instr(32'h0000_0008, 2'd3, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        do_instr(32'h1000_FFFF, 2'd1, 1, 0, 0, 0, 0, 1, 0, 0);
        do_instr(32'h1000_FFFF, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0);
        // lw at 0x40 with three dmem cycles
        do_instr(32'h0000_0008, 2'd3, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        do_instr(32'h8C22_0000, 2'd0, 0, 0, 1, 0, 0, 0, 2, 32'hDEAD_BEEF);
        // both dREN and dWEN: write wins
        do_instr(32'hAC22_0000, 2'd0, 0, 0, 1, 1, 0, 0, 1, 32'h1234_5678);
        // jr with misaligned target, jump in the top region, wrap at 2^32
        do_instr(32'h0000_0008, 2'd3, 0, 32'h103, 0, 0, 0, 1, 0, 0);
        do_instr(32'h0000_0008, 2'd3, 0, 32'hF000_0000, 0, 0, 0, 0, 0, 0);
        do_instr(32'h0800_0010, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0);
        do_instr(32'h0000_0008, 2'd3, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        do_instr(32'h2401_0005, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            do_instr($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0,
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        // reset while a load waits in DATA
        bus.cu_dren = 1; bus.cu_dwen = 0; bus.cu_halt = 0;
        bus.ihit = 1; bus.imemload = 32'h8C22_0000;
        end_cycle();
        bus.ihit = 0;
        end_cycle();
        @(negedge CLK);
        check_eq("middata_dmemREN", bus.dmemREN, 1);
        #1 nRST = 1'b0;
        #1 check_reset_values("middata_reset");
        @(posedge CLK);
        #1 nRST = 1'b1;
        bus.cu_dren = 0;
        do_instr(32'h2401_0005, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0);

        // halt: sticky, no commit, pc frozen, hits ignored
        do_instr(32'h0000_000C, 2'd0, 0, 0, 1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            bus.ihit = 1'($urandom_range(0, 1));
            bus.dhit = 1'($urandom_range(0, 1));
            bus.imemload = $urandom;
            bus.dmemload = $urandom;
            @(negedge CLK);
            check_eq("halted_halt", bus.halt, 1);
            check_eq("halted_commit", bus.commit, 0);
            check_eq("halted_imemREN", bus.imemREN, 0);
            check_eq("halted_dmemREN", bus.dmemREN, 0);
            check_eq("halted_dmemWEN", bus.dmemWEN, 0);
            check_eq("halted_pc", bus.pc, m_pc);
            check_eq("halted_instr", bus.instr, 32'h0000_000C);
            end_cycle();
        end
        check_perf();

        nRST = 1'b0;
        #1 check_reset_values("final_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
